// File: rtl/led_sequence_player_if.sv
// Host-side bus for led_sequence_player: table write port, playback
// control (len/start/abort) and playback status (busy/done/cur_idx).
interface led_sequence_player_if #(
  parameter int DEPTH  = 16,
  parameter int CODE_W = 5,
  parameter int NUM_CH = 3
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W  = $clog2(DEPTH + 1);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CH_W-1:0]   wr_ch;
  logic [CODE_W-1:0] wr_code;
  logic [LEN_W-1:0]  len;
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] cur_idx;

  modport master (
    output wr_en, wr_addr, wr_ch, wr_code, len, start, abort,
    input  busy, done, cur_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_ch, wr_code, len, start, abort,
    output busy, done, cur_idx
  );
endinterface

// File: rtl/led_sequence_player.sv
// Multi-channel LED symbol sequencer. Replays a host-loaded table of
// (channel, duration-code) entries as timed LED pulses, each followed by
// an all-off gap. All durations are in time units of CLK_DIV clocks.
// Optional feature macro: LED_PLAYER_LOOP_EN adds a 'loop' input that makes
// playback wrap back to entry 0 instead of finishing.
module led_sequence_player #(
  parameter int CLK_DIV   = 4,
  parameter int DEPTH     = 16,
  parameter int CODE_W    = 5,
  parameter int NUM_CH    = 3,
  parameter int GAP_UNITS = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef LED_PLAYER_LOOP_EN
  input  logic              loop,
`endif
  led_sequence_player_if.slave bus,
  output logic [NUM_CH-1:0] led
);

  localparam int ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int LEN_W    = $clog2(DEPTH + 1);
  localparam int TABLE_N  = 2 ** ADDR_W;
  localparam int TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CODE_MAX = (2 ** CODE_W) - 1;
  localparam int UNIT_MAX = (CODE_MAX > GAP_UNITS) ? CODE_MAX : GAP_UNITS;
  localparam int UNIT_W   = $clog2(UNIT_MAX + 1);
  localparam int ENTRY_W  = CH_W + CODE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_next;

  logic [ENTRY_W-1:0] table_mem [TABLE_N];
  logic [ENTRY_W-1:0] entry;
  logic [CODE_W-1:0]  entry_code;
  logic [CH_W-1:0]    entry_ch;

  logic [CH_W-1:0]   ch_q;
  logic [CODE_W-1:0] code_q;
  logic [TICK_W-1:0] tick;
  logic [UNIT_W-1:0] unit;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  len_sat;
  logic [ADDR_W-1:0] cur_idx_q;

  logic tick_wrap;
  logic on_end;
  logic gap_end;
  logic last_entry;
  logic start_take;
  logic abort_take;
  logic advance;
  logic restart;
  logic busy_int;

  assign entry      = table_mem[cur_idx_q];
  assign entry_code = entry[CODE_W-1:0];
  assign entry_ch   = entry[CODE_W +: CH_W];

  // A requested length longer than the table plays the whole table once.
  assign len_sat    = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;

  assign tick_wrap  = (tick == TICK_W'(CLK_DIV - 1));
  assign on_end     = tick_wrap && ((unit + UNIT_W'(1)) == UNIT_W'(code_q));
  assign gap_end    = tick_wrap && (unit == UNIT_W'(GAP_UNITS - 1));
  assign last_entry = (LEN_W'(cur_idx_q) == (len_q - LEN_W'(1)));

  assign bus.cur_idx = cur_idx_q;

  // Host table writes; locked out during playback so the running sequence is stable.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !busy_int) begin
      table_mem[bus.wr_addr] <= {bus.wr_ch, bus.wr_code};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus the strobes that steer the datapath registers.
  always_comb begin
    state_next = state;
    start_take = 1'b0;
    abort_take = 1'b0;
    advance    = 1'b0;
    restart    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          start_take = 1'b1;
          state_next = (len_sat == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        state_next = (entry_code != '0) ? S_ON : S_GAP;
      end
      S_ON: begin
        if (on_end) begin
          state_next = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_end) begin
          if (last_entry) begin
`ifdef LED_PLAYER_LOOP_EN
            if (loop) begin
              restart    = 1'b1;
              state_next = S_LOAD;
            end else begin
              state_next = S_DONE;
            end
`else
            state_next = S_DONE;
`endif
          end else begin
            advance    = 1'b1;
            state_next = S_LOAD;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    if ((state != S_IDLE) && bus.abort) begin
      abort_take = 1'b1;
      advance    = 1'b0;
      restart    = 1'b0;
      state_next = S_IDLE;
    end
  end

  // Playback datapath: length latch, entry index, current symbol and time counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      cur_idx_q <= '0;
      ch_q      <= '0;
      code_q    <= '0;
      tick      <= '0;
      unit      <= '0;
    end else begin
      if (start_take) begin
        len_q     <= len_sat;
        cur_idx_q <= '0;
      end
      if (abort_take || restart) begin
        cur_idx_q <= '0;
      end else if (advance) begin
        cur_idx_q <= cur_idx_q + ADDR_W'(1);
      end
      if (state == S_LOAD) begin
        ch_q   <= entry_ch;
        code_q <= entry_code;
      end
      if ((state_next != state) || ((state != S_ON) && (state != S_GAP))) begin
        tick <= '0;
        unit <= '0;
      end else if (tick_wrap) begin
        tick <= '0;
        unit <= unit + UNIT_W'(1);
      end else begin
        tick <= tick + TICK_W'(1);
      end
    end
  end

  // Status and LED drives decoded from state so reset clears them without waiting for clk.
  always_comb begin
    busy_int = (state == S_LOAD) || (state == S_ON) || (state == S_GAP);
    bus.busy = busy_int;
    bus.done = (state == S_DONE);
    led      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      led[i] = (state == S_ON) && (ch_q == CH_W'(i));
    end
  end

endmodule
